dag_dm_addr: RTL and testbench

//  Data address generator feeding the data memory's dg_dm_add port. Holds index (I), modify (M),

---
 rtl/dag_dm_addr.sv | 146 ++++++++++++++
 tb/tb_dag_dm_addr.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dag_dm_addr.sv
// Data address generator for the data memory.
// Holds I/M/L/B register banks and emits one registered DM address per request.
// Pre-modify emits the modified address. Post-modify emits I and then advances I.
// A non-zero L selects circular-buffer wrap within [B, B+L).
// Optional feature: define DAG_BITREV_EN to enable bit-reversed output addressing.
module dag_dm_addr #(
  parameter int DMA_SIZE  = 16,
  parameter int NREG_W    = 2,
  parameter int UREG_SIZE = 16
) (
  input  logic                 clk_dcd,
  input  logic                 reset,
  input  logic                 ps_dg_en,
  input  logic                 ps_dg_pre,
  input  logic [NREG_W-1:0]    ps_dg_iadd,
  input  logic [NREG_W-1:0]    ps_dg_madd,
  input  logic                 ps_dg_imm,
  input  logic [DMA_SIZE-1:0]  ps_dg_immval,
  input  logic                 ps_dg_brev,
  input  logic                 ps_dg_wrt_en,
  input  logic                 ps_dg_rd_en,
  input  logic [1:0]           ps_dg_ureg_bank,
  input  logic [NREG_W-1:0]    ps_dg_ureg_idx,
  input  logic [UREG_SIZE-1:0] bc_dg_dt,
  output logic [DMA_SIZE-1:0]  dg_dm_add,
  output logic                 dg_dm_vld,
  output logic [UREG_SIZE-1:0] dg_bc_dt
);

  localparam int NREG = 1 << NREG_W;
  localparam int WMAX = (UREG_SIZE > DMA_SIZE) ? UREG_SIZE : DMA_SIZE;

  typedef enum logic [1:0] {
    BANK_I = 2'b00,
    BANK_M = 2'b01,
    BANK_L = 2'b10,
    BANK_B = 2'b11
  } bank_e;

  logic [DMA_SIZE-1:0] i_reg [NREG];
  logic [DMA_SIZE-1:0] m_reg [NREG];
  logic [DMA_SIZE-1:0] l_reg [NREG];
  logic [DMA_SIZE-1:0] b_reg [NREG];

  logic [DMA_SIZE-1:0] cur_i, cur_l, cur_b, mod_val, sum, wrapped;
  logic [DMA_SIZE:0]   upper;
  logic [DMA_SIZE-1:0] addr_sel, addr_out;
  logic [WMAX-1:0]     wr_ext, rd_ext;
  logic [DMA_SIZE-1:0] wr_val, rd_val;

  // Address arithmetic: modify, add, then a single circular-buffer correction.
  always_comb begin
    cur_i   = i_reg[ps_dg_iadd];
    cur_l   = l_reg[ps_dg_iadd];
    cur_b   = b_reg[ps_dg_iadd];
    mod_val = ps_dg_imm ? ps_dg_immval : m_reg[ps_dg_madd];
    sum     = cur_i + mod_val;
    // One extra bit keeps B+L from aliasing when the buffer ends at the top of memory.
    upper   = {1'b0, cur_b} + {1'b0, cur_l};
    wrapped = sum;
    if (cur_l != '0) begin
      if ({1'b0, sum} >= upper) begin
        wrapped = sum - cur_l;
      end else if (sum < cur_b) begin
        wrapped = sum + cur_l;
      end
    end
    addr_sel = ps_dg_pre ? wrapped : cur_i;
  end

`ifdef DAG_BITREV_EN
  // Optional bit reversal of the emitted address; the I update is never reversed.
  always_comb begin
    addr_out = addr_sel;
    if (ps_dg_brev) begin
      for (int k = 0; k < DMA_SIZE; k++) begin
        addr_out[k] = addr_sel[DMA_SIZE-1-k];
      end
    end
  end
`else
  assign addr_out = addr_sel;
  logic unused_brev;
  assign unused_brev = ps_dg_brev;
`endif

  // Ureg data path: truncate or zero-extend between the bus and register widths.
  always_comb begin
    wr_ext = WMAX'(bc_dg_dt);
    wr_val = wr_ext[DMA_SIZE-1:0];
    unique case (bank_e'(ps_dg_ureg_bank))
      BANK_I:  rd_val = i_reg[ps_dg_ureg_idx];
      BANK_M:  rd_val = m_reg[ps_dg_ureg_idx];
      BANK_L:  rd_val = l_reg[ps_dg_ureg_idx];
      default: rd_val = b_reg[ps_dg_ureg_idx];
    endcase
    rd_ext = WMAX'(rd_val);
  end

  // Register banks: post-modify I update, then ureg writes which take priority.
  always_ff @(posedge clk_dcd or negedge reset) begin
    if (!reset) begin
      // NOTE: the banks are software-visible state with a defined reset value, so every entry is cleared.
      for (int k = 0; k < NREG; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
    end else begin
      if (ps_dg_en && !ps_dg_pre) begin
        i_reg[ps_dg_iadd] <= wrapped;
      end
      // NOTE: non-blocking assignments resolve last-wins, so this ureg write overrides the I update above.
      if (ps_dg_wrt_en) begin
        unique case (bank_e'(ps_dg_ureg_bank))
          BANK_I: i_reg[ps_dg_ureg_idx] <= wr_val;
          BANK_M: m_reg[ps_dg_ureg_idx] <= wr_val;
          BANK_L: l_reg[ps_dg_ureg_idx] <= wr_val;
          default: begin
            b_reg[ps_dg_ureg_idx] <= wr_val;
            i_reg[ps_dg_ureg_idx] <= wr_val;
          end
        endcase
      end
    end
  end

  // Output registers: address with a one-cycle valid pulse, and ureg read data.
  always_ff @(posedge clk_dcd or negedge reset) begin
    if (!reset) begin
      dg_dm_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_bc_dt  <= '0;
    end else begin
      dg_dm_vld <= ps_dg_en;
      if (ps_dg_en) begin
        dg_dm_add <= addr_out;
      end
      if (ps_dg_rd_en) begin
        dg_bc_dt <= rd_ext[UREG_SIZE-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dag_dm_addr.sv
// Directed self-checking bench for dag_dm_addr (default parameters).
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_dag_dm_addr;

  logic        clk_dcd = 1'b0;
  logic        reset   = 1'b0;
  logic        ps_dg_en = 1'b0, ps_dg_pre = 1'b0, ps_dg_imm = 1'b0, ps_dg_brev = 1'b0;
  logic [1:0]  ps_dg_iadd = '0, ps_dg_madd = '0;
  logic [15:0] ps_dg_immval = '0;
  logic        ps_dg_wrt_en = 1'b0, ps_dg_rd_en = 1'b0;
  logic [1:0]  ps_dg_ureg_bank = '0, ps_dg_ureg_idx = '0;
  logic [15:0] bc_dg_dt = '0;
  logic [15:0] dg_dm_add;
  logic        dg_dm_vld;
  logic [15:0] dg_bc_dt;

  int n_checks = 0;
  int n_fail   = 0;

  dag_dm_addr dut (
    .clk_dcd(clk_dcd), .reset(reset),
    .ps_dg_en(ps_dg_en), .ps_dg_pre(ps_dg_pre), .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
    .ps_dg_imm(ps_dg_imm), .ps_dg_immval(ps_dg_immval), .ps_dg_brev(ps_dg_brev),
    .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_rd_en(ps_dg_rd_en),
    .ps_dg_ureg_bank(ps_dg_ureg_bank), .ps_dg_ureg_idx(ps_dg_ureg_idx), .bc_dg_dt(bc_dg_dt),
    .dg_dm_add(dg_dm_add), .dg_dm_vld(dg_dm_vld), .dg_bc_dt(dg_bc_dt)
  );

  always #5 clk_dcd = ~clk_dcd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic ureg_wr(input logic [1:0] bank, input logic [1:0] idx, input logic [15:0] data);
    ps_dg_wrt_en = 1'b1; ps_dg_ureg_bank = bank; ps_dg_ureg_idx = idx; bc_dg_dt = data;
    @(negedge clk_dcd);
    ps_dg_wrt_en = 1'b0;
  endtask

  task automatic ureg_rd(input string tag, input logic [1:0] bank, input logic [1:0] idx,
                         input logic [15:0] exp);
    ps_dg_rd_en = 1'b1; ps_dg_ureg_bank = bank; ps_dg_ureg_idx = idx;
    @(negedge clk_dcd);
    ps_dg_rd_en = 1'b0;
    check(tag, dg_bc_dt, exp);
  endtask

  // Leaves the request asserted so consecutive calls are back-to-back.
  task automatic req(input string tag, input logic pre, input logic [1:0] iadd, input logic [1:0] madd,
                     input logic imm, input logic [15:0] immval, input logic brev,
                     input logic [15:0] exp_add);
    ps_dg_en = 1'b1; ps_dg_pre = pre; ps_dg_iadd = iadd; ps_dg_madd = madd;
    ps_dg_imm = imm; ps_dg_immval = immval; ps_dg_brev = brev;
    @(negedge clk_dcd);
    check({tag, "_add"}, dg_dm_add, exp_add);
    check({tag, "_vld"}, 16'(dg_dm_vld), 16'h0001);
  endtask

  task automatic idle(input string tag, input logic [15:0] exp_hold);
    ps_dg_en = 1'b0; ps_dg_imm = 1'b0; ps_dg_brev = 1'b0;
    @(negedge clk_dcd);
    check({tag, "_vld0"}, 16'(dg_dm_vld), 16'h0000);
    check({tag, "_hold"}, dg_dm_add, exp_hold);
  endtask

  initial begin
    // 1. Reset behaviour, including reset asserted during a request.
    @(negedge clk_dcd);
    check("rst_add", dg_dm_add, 16'h0000);
    check("rst_vld", 16'(dg_dm_vld), 16'h0000);
    check("rst_bc", dg_bc_dt, 16'h0000);
    reset = 1'b1;
    @(negedge clk_dcd);
    ureg_wr(2'b00, 2'd0, 16'h1234);
    ureg_rd("t1_rd_i0", 2'b00, 2'd0, 16'h1234);
    req("t1_pre_rst", 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'h1234);
    #2 reset = 1'b0;
    #1;
    check("t1_midrst_add", dg_dm_add, 16'h0000);
    check("t1_midrst_vld", 16'(dg_dm_vld), 16'h0000);
    check("t1_midrst_bc", dg_bc_dt, 16'h0000);
    ps_dg_en = 1'b0;
    @(negedge clk_dcd);
    reset = 1'b1;
    @(negedge clk_dcd);
    req("t1_post", 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    idle("t1_idle", 16'h0000);

    // 2. Linear post-modify, back-to-back on I1.
    ureg_wr(2'b00, 2'd1, 16'h0010);
    ureg_wr(2'b01, 2'd1, 16'h0004);
    req("t2_a", 1'b0, 2'd1, 2'd1, 1'b0, 16'h0000, 1'b0, 16'h0010);
    req("t2_b", 1'b0, 2'd1, 2'd1, 1'b0, 16'h0000, 1'b0, 16'h0014);
    req("t2_c", 1'b0, 2'd1, 2'd1, 1'b0, 16'h0000, 1'b0, 16'h0018);
    idle("t2_idle", 16'h0018);
    ureg_rd("t2_rd_i1", 2'b00, 2'd1, 16'h001C);

    // 3. Circular buffer B2=0x100, L2=8, immediate +3 then -3.
    ureg_wr(2'b11, 2'd2, 16'h0100);
    ureg_rd("t3_rd_i2", 2'b00, 2'd2, 16'h0100);
    ureg_wr(2'b10, 2'd2, 16'h0008);
    req("t3_a", 1'b0, 2'd2, 2'd0, 1'b1, 16'h0003, 1'b0, 16'h0100);
    req("t3_b", 1'b0, 2'd2, 2'd0, 1'b1, 16'h0003, 1'b0, 16'h0103);
    req("t3_c", 1'b0, 2'd2, 2'd0, 1'b1, 16'h0003, 1'b0, 16'h0106);
    req("t3_d", 1'b0, 2'd2, 2'd0, 1'b1, 16'h0003, 1'b0, 16'h0101);
    idle("t3_idle", 16'h0101);
    ureg_rd("t3_rd_i2_wrap", 2'b00, 2'd2, 16'h0104);
    ureg_wr(2'b00, 2'd2, 16'h0101);
    req("t3_neg", 1'b0, 2'd2, 2'd0, 1'b1, 16'hFFFD, 1'b0, 16'h0101);
    idle("t3_neg_idle", 16'h0101);
    ureg_rd("t3_rd_i2_neg", 2'b00, 2'd2, 16'h0106);

    // 4. Pre-modify with immediate -1: address moves, I3 does not.
    ureg_wr(2'b00, 2'd3, 16'h0020);
    req("t4_pre", 1'b1, 2'd3, 2'd0, 1'b1, 16'hFFFF, 1'b0, 16'h001F);
    idle("t4_idle", 16'h001F);
    ureg_rd("t4_rd_i3", 2'b00, 2'd3, 16'h0020);

    // 5. Same-cycle post-modify on I0 and ureg write of I0: the write wins.
    ureg_wr(2'b01, 2'd0, 16'h0002);
    ps_dg_wrt_en = 1'b1; ps_dg_ureg_bank = 2'b00; ps_dg_ureg_idx = 2'd0; bc_dg_dt = 16'h0500;
    req("t5_req", 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    ps_dg_wrt_en = 1'b0;
    idle("t5_idle", 16'h0000);
    ureg_rd("t5_rd_i0", 2'b00, 2'd0, 16'h0500);

    // Read and write of the same register in one cycle returns the old value.
    ps_dg_wrt_en = 1'b1; ps_dg_ureg_bank = 2'b01; ps_dg_ureg_idx = 2'd1; bc_dg_dt = 16'h0AAA;
    ureg_rd("t5_rdwr_old", 2'b01, 2'd1, 16'h0004);
    ps_dg_wrt_en = 1'b0;
    @(negedge clk_dcd);
    check("t5_bc_hold", dg_bc_dt, 16'h0004);
    ureg_rd("t5_rdwr_new", 2'b01, 2'd1, 16'h0AAA);

    // 6. Bit-reversed pre-modify output.
    ureg_wr(2'b00, 2'd0, 16'h0001);
`ifdef DAG_BITREV_EN
    req("t6_brev", 1'b1, 2'd0, 2'd0, 1'b1, 16'h0000, 1'b1, 16'h8000);
    idle("t6_idle", 16'h8000);
`else
    req("t6_brev", 1'b1, 2'd0, 2'd0, 1'b1, 16'h0000, 1'b1, 16'h0001);
    idle("t6_idle", 16'h0001);
`endif
    ureg_rd("t6_rd_i0", 2'b00, 2'd0, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
